// File: rtl/regfile_arbiter_pkg.sv
// Shared types and default widths for the register-file arbiter slice.
package regfile_arb_pkg;

  localparam int AW_DEF = 2;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] pos;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = PW'((32'(ptr) + k) % NREQ);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin front end for a single-port register file shared by NREQ requesters.
// Optional per-requester grant counters are enabled with REGFILE_ARB_STATS_EN.
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_wr,
  input  logic [NREQ*AW-1:0]      req_addr,
  input  logic [NREQ*DW-1:0]      req_wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [DW-1:0]           rsp_rdata,
  output logic                    busy,
  output logic                    rf_sel,
  output logic                    rf_wr,
  output logic [AW-1:0]           rf_addr,
  output logic [DW-1:0]           rf_wdata,
  input  logic [DW-1:0]           rf_rdata
`ifdef REGFILE_ARB_STATS_EN
  ,
  input  logic [$clog2(NREQ)-1:0] stat_sel,
  output logic [15:0]             stat_cnt
`endif
);

  localparam int PW = $clog2(NREQ);

  state_t        state, state_nxt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win_idx;
  logic [NREQ-1:0] arb_grant;
  logic [PW-1:0]   arb_idx;
  logic            arb_any;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_any) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The rf_* registers double as the latched request fields, so outputs stay registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      win_idx   <= '0;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      rf_sel    <= 1'b0;
      rf_wr     <= 1'b0;
      rf_addr   <= '0;
      rf_wdata  <= '0;
      rsp_rdata <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            gnt      <= arb_grant;
            win_idx  <= arb_idx;
            busy     <= 1'b1;
            rf_sel   <= 1'b1;
            rf_wr    <= req_wr[arb_idx];
            rf_addr  <= req_addr[int'(arb_idx)*AW +: AW];
            rf_wdata <= req_wdata[int'(arb_idx)*DW +: DW];
          end
        end
        ACCESS: begin
          rf_sel <= 1'b0;
          rf_wr  <= 1'b0;
          done   <= gnt;
          if (!rf_wr) rsp_rdata <= rf_rdata;
        end
        RESP: begin
          gnt  <= '0;
          busy <= 1'b0;
          ptr  <= (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] grant_cnt [NREQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
    end else if (state == RESP && grant_cnt[win_idx] != '1) begin
      grant_cnt[win_idx] <= grant_cnt[win_idx] + 16'd1;
    end
  end

  assign stat_cnt = (int'(stat_sel) < NREQ) ? grant_cnt[stat_sel] : '0;
`endif

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Shares the single-port 4x16 register file between NREQ independent requesters. Requesters raise a request with address, direction and write data. The block picks one by round-robin, sequences one register-file access (sel/wr/addr/wdata), returns read data and signals completion. It sits directly in front of the register file, and the register file's port signals are driven only by this block.

## Interface
Parameters:
- NREQ, 3, number of requesters (2..8)
- AW, 2, register-file address width
- DW, 16, data width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- req  in  NREQ  request per requester; held high until its done pulse
- req_wr  in  NREQ  1 = write, 0 = read, per requester
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data, requester i at [i*DW +: DW]
- gnt  out  NREQ  one-hot; high from arbitration until done
- done  out  NREQ  one-cycle completion pulse to the granted requester
- rsp_rdata  out  DW  read data; valid in the done cycle of a read
- busy  out  1  high when state is not IDLE
- rf_sel, rf_wr  out  1 each  register-file select and write enable
- rf_addr  out  AW  register-file address
- rf_wdata  out  DW  register-file write data
- rf_rdata  in  DW  register-file read data (combinational, valid when rf_sel & ~rf_wr)

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE with any req high:
  - Select a winner by round-robin. The search starts at ptr and wraps modulo NREQ.
  - Latch the winner's wr, addr and wdata. Set gnt[winner]. Go to ACCESS.
- ACCESS (exactly one cycle):
  - rf_sel=1; rf_wr, rf_addr, rf_wdata come from the latched fields.
  - Read: capture rf_rdata into rsp_rdata at the closing edge.
  - Write: takes effect in the register file at the closing edge.
  - Go to RESP.
- RESP (one cycle):
  - rf_sel=0, rf_wr=0; done[winner]=1; gnt stays high.
  - ptr is set to winner+1, wrapping NREQ-1 to 0. Go to IDLE, which clears gnt.
- rsp_rdata holds its value until the next read completes. Writes leave it unchanged.
- Request fields are sampled only in IDLE. A requester dropping req or changing fields after grant does not affect the in-flight access, and the access completes with done.
- req still high in the cycle after done counts as a new request.
- rf_sel is never asserted outside ACCESS, so the register file never sees a stray write.

## Timing
- Reset values: ptr=0; state=IDLE; gnt, done, busy, rf_sel and rf_wr are 0; rf_addr, rf_wdata and rsp_rdata are 0.
- Latency: req seen in IDLE at cycle 0 → rf_sel in cycle 1 → done in cycle 2. Minimum 3 cycles per transaction, including the return to IDLE.
- Simultaneous requests: exactly one is granted. Each other waiting requester is served within NREQ transactions, with no starvation.
- Reset asserted mid-transaction: all outputs go to reset values immediately (asynchronously), no done is issued, and an ACCESS write in progress is dropped unless the edge has already occurred.
- All outputs are registered. There is no combinational path from req to rf_* or gnt.

## Configuration
- REGFILE_ARB_STATS_EN defined:
  - Adds a 16-bit saturating grant counter per requester, incremented in RESP and held at 16'hFFFF.
  - Adds port stat_sel (in, clog2(NREQ)) and stat_cnt (out, 16), where stat_cnt = counter[stat_sel] as a combinational read.
  - Counters reset to 0.
- Undefined: no counters and no stat ports. All other behaviour is identical.

## Structure
- Package regfile_arb_pkg holds the state enum (IDLE, ACCESS, RESP) and the default AW/DW constants.
- Sub-module rr_arbiter takes req and ptr and produces a one-hot winner and its index. It is purely combinational, and the parent holds ptr.
- The FSM, the latched fields and the optional stats all live in regfile_arbiter.

## Test plan
- Single write: req[0] with wr=1, addr=2, wdata=16'hBEEF → rf_sel=rf_wr=1 with addr=2 in cycle 1; done[0] in cycle 2; a later read of addr 2 returns 16'hBEEF.
- Read after write: requester 1 reads addr 2 → rsp_rdata=16'hBEEF in its done cycle; rsp_rdata unchanged by a following write.
- Contention: req=3'b111 held continuously from reset → grant order 0,1,2,0,1,2, with done every 3 cycles.
- Field change after grant: requester 2 changes addr from 1 to 3 during ACCESS → register-file access still uses addr 1.
- Reset mid-ACCESS: rst low while rf_sel=1 → rf_sel, gnt and done are 0 immediately and no done pulse follows; after release, ptr=0 and requester 0 wins.
- With REGFILE_ARB_STATS_EN: 70000 grants to requester 0 → stat_cnt with stat_sel=0 reads 16'hFFFF.
